// File: rtl/sb_rx_deser_pkg.sv
// Shared types and default sizing for the sideband receive deserializer.
package sb_rx_deser_pkg;

   // Receive FSM states: waiting for a first bit, mid-packet, post-packet gap.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } sb_rx_state_e;

   localparam int SB_PKT_W  = 64;
   localparam int SB_GAP_UI = 32;

endpackage

// File: rtl/sb_gap_timer.sv
// Saturating counter of consecutive idle (valid-low) cycles on the sideband lane.
// Preset forces the "gap already satisfied" value; clear restarts counting.
module sb_gap_timer
   import sb_rx_deser_pkg::*;
#(
   parameter int GAP_UI = SB_GAP_UI
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_preset,
   input  logic i_clear,
   input  logic i_idle,
   output logic o_gap_met,
   output logic o_reach
);

   localparam int CNT_W = $clog2(GAP_UI + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GAP_UI);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(GAP_UI - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: preset beats clear, clear beats a saturating increment.
   always_comb begin
      cnt_d = cnt_q;
      if (i_preset) begin
         cnt_d = CNT_MAX;
      end else if (i_clear) begin
         cnt_d = '0;
      end else if (i_idle && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Count register; out of reset the gap counts as already met.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= CNT_MAX;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_gap_met = (cnt_q == CNT_MAX);
   // High on the idle cycle whose edge brings the count up to GAP_UI.
   assign o_reach   = i_idle && !i_preset && !i_clear && (cnt_q == CNT_PRE);

endmodule

// File: rtl/sb_rx_deserializer.sv
// Sideband RX deserializer: shifts in one bit per valid cycle, hands each
// completed packet to the consumer with a level done/ack handshake, and flags
// short inter-packet gaps, mid-packet timeouts and unconsumed-packet overruns.
module sb_rx_deserializer
   import sb_rx_deser_pkg::*;
#(
   parameter int PKT_W     = SB_PKT_W,
   parameter int GAP_UI    = SB_GAP_UI,
   parameter int LSB_FIRST = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  logic             i_ser_data,
   input  logic             i_ser_valid,
   input  logic             i_de_ser_done_sampled,
   output logic [PKT_W-1:0] o_deser_data,
   output logic             o_de_ser_done,
   output logic             o_gap_violation,
   output logic             o_frame_error,
   output logic             o_overrun
);

   localparam int CNT_W = $clog2(PKT_W);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PKT_W - 1);
   localparam logic [CNT_W-1:0] BIT_ONE  = CNT_W'(1);

   sb_rx_state_e     state_q,   state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [PKT_W-1:0] shift_q,   shift_d;
   logic             cmpl_q,    cmpl_d;
   logic [PKT_W-1:0] data_q,    data_d;
   logic             done_q,    done_d;
   logic             gapv_q,    gapv_d;
   logic             ferr_q,    ferr_d;
   logic             ovr_q,     ovr_d;

   logic [PKT_W-1:0] shift_in;
   logic             gap_met;
   logic             idle_reach;

   // Bit ordering is fixed at elaboration: after PKT_W shifts the first bit
   // sits at bit 0 (LSB first) or at bit PKT_W-1 (MSB first).
   generate
      if (LSB_FIRST != 0) begin : g_lsb_first
         assign shift_in = {i_ser_data, shift_q[PKT_W-1:1]};
      end else begin : g_msb_first
         assign shift_in = {shift_q[PKT_W-2:0], i_ser_data};
      end
   endgenerate

   // One timer serves both roles: inter-packet gap and mid-packet idle timeout,
   // since both count consecutive valid-low cycles since the last bit.
   sb_gap_timer #(
      .GAP_UI (GAP_UI)
   ) u_gap_timer (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_preset  (!i_enable),
      .i_clear   (i_enable && i_ser_valid),
      .i_idle    (i_enable && !i_ser_valid),
      .o_gap_met (gap_met),
      .o_reach   (idle_reach)
   );

   // Next-state: packet handoff to the consumer, then FSM/shift bookkeeping.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      cmpl_d    = 1'b0;
      data_d    = data_q;
      done_d    = done_q;
      gapv_d    = 1'b0;
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;

      if (!i_enable) begin
         // Output data deliberately survives a disable; everything else clears.
         state_d   = IDLE;
         bit_cnt_d = '0;
         shift_d   = '0;
         done_d    = 1'b0;
      end else begin
         // cmpl_q marks the cycle after the last bit; shift_q still holds the
         // whole packet here even if a new packet starts shifting this cycle.
         if (cmpl_q) begin
            if (!done_q || i_de_ser_done_sampled) begin
               data_d = shift_q;
               done_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end else if (i_de_ser_done_sampled) begin
            done_d = 1'b0;
         end

         unique case (state_q)
            IDLE, GAP: begin
               if (i_ser_valid) begin
                  shift_d   = shift_in;
                  bit_cnt_d = BIT_ONE;
                  state_d   = SHIFT;
                  gapv_d    = !gap_met;
               end
            end
            SHIFT: begin
               if (i_ser_valid) begin
                  shift_d = shift_in;
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_d = '0;
                     cmpl_d    = 1'b1;
                     state_d   = GAP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_ONE;
                  end
               end else if (idle_reach) begin
                  // Lane went quiet too long mid-packet: drop the fragment.
                  ferr_d    = 1'b1;
                  bit_cnt_d = '0;
                  shift_d   = '0;
                  state_d   = IDLE;
               end
            end
            default: begin
               state_d   = IDLE;
               bit_cnt_d = '0;
            end
         endcase
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         cmpl_q    <= 1'b0;
         data_q    <= '0;
         done_q    <= 1'b0;
         gapv_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         cmpl_q    <= cmpl_d;
         data_q    <= data_d;
         done_q    <= done_d;
         gapv_q    <= gapv_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   assign o_deser_data    = data_q;
   assign o_de_ser_done   = done_q;
   assign o_gap_violation = gapv_q;
   assign o_frame_error   = ferr_q;
   assign o_overrun       = ovr_q;

endmodule

// File: tb/tb_sb_rx_deserializer.sv
// Bench for sb_rx_deserializer: directed scenarios followed by randomized
// traffic, every cycle compared against a queue-based packet model.
module tb_sb_rx_deserializer;
   import sb_rx_deser_pkg::*;

   localparam int PKT_W     = SB_PKT_W;
   localparam int GAP_UI    = SB_GAP_UI;
   localparam int LSB_FIRST = 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             sd = 1'b0;
   logic             sv = 1'b0;
   logic             ack = 1'b0;
   logic [PKT_W-1:0] dout;
   logic             done, gapv, ferr, ovr;

   always #5 clk = ~clk;

   sb_rx_deserializer #(
      .PKT_W     (PKT_W),
      .GAP_UI    (GAP_UI),
      .LSB_FIRST (LSB_FIRST)
   ) dut (
      .i_clk                 (clk),
      .i_rst_n               (rst_n),
      .i_enable              (en),
      .i_ser_data            (sd),
      .i_ser_valid           (sv),
      .i_de_ser_done_sampled (ack),
      .o_deser_data          (dout),
      .o_de_ser_done         (done),
      .o_gap_violation       (gapv),
      .o_frame_error         (ferr),
      .o_overrun             (ovr)
   );

   int n_checks = 0;
   int n_errors = 0;
   int gapv_seen = 0;
   int ferr_seen = 0;
   int ovr_seen = 0;

   // Reference model: bits gathered so far, consecutive idle cycles, and
   // the consumer-visible packet/flag state.
   bit               m_bits[$];
   int               m_idle;
   bit               m_inpkt, m_pend, m_done, m_gapv, m_ferr, m_ovr;
   logic [PKT_W-1:0] m_pend_data, m_data;

   task automatic chk(input string tag, input logic [PKT_W-1:0] got, input logic [PKT_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [PKT_W-1:0] pack_bits();
      logic [PKT_W-1:0] v = '0;
      for (int i = 0; i < m_bits.size(); i++) begin
         if (LSB_FIRST != 0) v[i] = m_bits[i];
         else                v[PKT_W-1-i] = m_bits[i];
      end
      return v;
   endfunction

   task automatic model_reset();
      m_bits.delete();
      m_idle = GAP_UI;
      m_inpkt = 0; m_pend = 0; m_done = 0;
      m_gapv = 0; m_ferr = 0; m_ovr = 0;
      m_pend_data = '0; m_data = '0;
   endtask

   // One clock edge of the model, given the inputs seen at that edge.
   task automatic model_edge(input bit e, input bit v, input bit d, input bit a);
      m_gapv = 0; m_ferr = 0; m_ovr = 0;
      if (!e) begin
         m_bits.delete();
         m_idle = GAP_UI;
         m_inpkt = 0; m_pend = 0; m_done = 0;
         return;
      end
      // A packet finished on the previous edge is offered to the consumer now.
      if (m_pend) begin
         if (!m_done || a) begin
            m_data = m_pend_data;
            m_done = 1;
         end else begin
            m_ovr = 1;
         end
      end else if (a) begin
         m_done = 0;
      end
      m_pend = 0;
      if (v) begin
         if (!m_inpkt) begin
            m_gapv = (m_idle < GAP_UI);
            m_inpkt = 1;
            m_bits.delete();
         end
         m_bits.push_back(d);
         m_idle = 0;
         if (m_bits.size() == PKT_W) begin
            m_pend = 1;
            m_pend_data = pack_bits();
            m_inpkt = 0;
            m_bits.delete();
         end
      end else begin
         if (m_idle < GAP_UI) m_idle++;
         if (m_inpkt && m_idle == GAP_UI) begin
            m_ferr = 1;
            m_inpkt = 0;
            m_bits.delete();
         end
      end
   endtask

   task automatic step(input bit e, input bit v, input bit d, input bit a);
      en = e; sv = v; sd = d; ack = a;
      @(posedge clk);
      model_edge(e, v, d, a);
      #1;
      if (gapv === 1'b1) gapv_seen++;
      if (ferr === 1'b1) ferr_seen++;
      if (ovr === 1'b1)  ovr_seen++;
      chk("done", done, m_done);
      chk("data", dout, m_data);
      chk("gapv", gapv, m_gapv);
      chk("ferr", ferr, m_ferr);
      chk("ovr",  ovr,  m_ovr);
   endtask

   function automatic bit rnd_ack(input bit rnd);
      return rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
   endfunction

   task automatic idle(input int n, input bit rnd);
      for (int k = 0; k < n; k++) step(1, 0, 0, rnd_ack(rnd));
   endtask

   // Send the first nbits of p in wire order, optionally pausing before bit pause_at.
   task automatic send_pkt(input logic [PKT_W-1:0] p, input int nbits,
                           input int pause_at, input int pause_len, input bit rnd);
      logic [PKT_W-1:0] pv;
      pv = p;
      for (int i = 0; i < nbits; i++) begin
         if (i == pause_at) idle(pause_len, rnd);
         step(1, 1, (LSB_FIRST != 0) ? pv[i] : pv[PKT_W-1-i], rnd_ack(rnd));
      end
   endtask

   initial begin
      logic [PKT_W-1:0] p1, p2;
      int g0, f0, o0;
      int gap, pat, plen;

      model_reset();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_done", done, 0);
      chk("rst_data", dout, 0);
      chk("rst_gapv", gapv, 0);
      chk("rst_ferr", ferr, 0);
      chk("rst_ovr",  ovr,  0);

      // T1: single packet, no ack, 1-cycle completion latency, done holds.
      p1 = 64'hA5A5_0000_DEAD_BEEF;
      send_pkt(p1, PKT_W, -1, 0, 0);
      chk("t1_lat", done, 0);
      step(1, 0, 0, 0);
      chk("t1_done", done, 1);
      chk("t1_data", dout, p1);
      idle(80, 0);
      chk("t1_hold", done, 1);
      $display("T1 packet data=%h done=%b", dout, done);

      // T2: back-to-back with exact gap; ack P1 on P2's completion edge.
      step(1, 0, 0, 1);
      idle(32, 0);
      send_pkt(64'h1, PKT_W, -1, 0, 0);
      idle(32, 0);
      chk("t2_p1", dout, 64'h1);
      o0 = ovr_seen;
      g0 = gapv_seen;
      send_pkt(64'h2, PKT_W, -1, 0, 0);
      step(1, 0, 0, 1);
      chk("t2_ovr", ovr_seen - o0, 0);
      chk("t2_gapv", gapv_seen - g0, 0);
      chk("t2_data", dout, 64'h2);
      chk("t2_done", done, 1);
      $display("T2 collision ack data=%h done=%b", dout, done);

      // T3: second completion with the first unacked -> overrun, data kept.
      step(1, 0, 0, 1);
      idle(32, 0);
      p1 = {$urandom, $urandom};
      p2 = ~p1;
      send_pkt(p1, PKT_W, -1, 0, 0);
      idle(32, 0);
      o0 = ovr_seen;
      send_pkt(p2, PKT_W, -1, 0, 0);
      step(1, 0, 0, 0);
      chk("t3_ovr", ovr_seen - o0, 1);
      chk("t3_data", dout, p1);
      step(1, 0, 0, 0);
      chk("t3_pulse", ovr, 0);
      $display("T3 overrun data=%h", dout);

      // T4: only 10 idle cycles before the next packet -> gap violation.
      step(1, 0, 0, 1);
      idle(32, 0);
      send_pkt({$urandom, $urandom}, PKT_W, -1, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 1);
      idle(8, 0);
      p2 = {$urandom, $urandom};
      g0 = gapv_seen;
      send_pkt(p2, PKT_W, -1, 0, 0);
      chk("t4_gapv", gapv_seen - g0, 1);
      step(1, 0, 0, 0);
      chk("t4_done", done, 1);
      chk("t4_data", dout, p2);
      $display("T4 short gap data=%h", dout);

      // T5: short pause is tolerated, a GAP_UI pause is a framing error.
      step(1, 0, 0, 1);
      idle(32, 0);
      p1 = {$urandom, $urandom};
      f0 = ferr_seen;
      send_pkt(p1, PKT_W, 20, 5, 0);
      step(1, 0, 0, 0);
      chk("t5_ferr0", ferr_seen - f0, 0);
      chk("t5_data", dout, p1);
      step(1, 0, 0, 1);
      idle(32, 0);
      f0 = ferr_seen;
      send_pkt({$urandom, $urandom}, 20, -1, 0, 0);
      idle(32, 0);
      chk("t5_ferr", ferr_seen - f0, 1);
      step(1, 0, 0, 0);
      chk("t5_nodone", done, 0);
      $display("T5 pause/timeout frame_errors=%0d", ferr_seen - f0);

      // T6: one-cycle disable at bit 40, then an immediate clean packet.
      send_pkt({$urandom, $urandom}, 40, -1, 0, 0);
      step(0, 1, 1, 0);
      chk("t6_done", done, 0);
      p2 = {$urandom, $urandom};
      g0 = gapv_seen;
      send_pkt(p2, PKT_W, -1, 0, 0);
      step(1, 0, 0, 0);
      chk("t6_gapv", gapv_seen - g0, 0);
      chk("t6_data", dout, p2);
      chk("t6_done", done, 1);
      $display("T6 disable recovery data=%h", dout);

      // Randomized traffic: gaps, pauses, acks and disables at random.
      for (int t = 0; t < 40; t++) begin
         gap = $urandom_range(0, 40);
         idle(gap, 1);
         if ($urandom_range(0, 9) == 0) step(0, $urandom_range(0, 1), $urandom_range(0, 1), rnd_ack(1));
         pat  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, PKT_W - 1) : -1;
         plen = $urandom_range(1, 40);
         p1 = {$urandom, $urandom};
         send_pkt(p1, PKT_W, pat, plen, 1);
         $display("txn %0d gap=%0d pause_at=%0d len=%0d sent=%h out=%h done=%b",
                  t, gap, pat, plen, p1, dout, done);
      end
      idle(4, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
